zbt_frame_copier: RTL and testbench

ZBT_FRAME_COPIER -- requirements
Module: zbt_frame_copier

---
 rtl/zbt_frame_copier.sv | 145 ++++++++++++++
 tb/tb_zbt_frame_copier.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_frame_copier.sv
// zbt_frame_copier: copies one frame from a source ZBT bank to a destination
// bank. Each word passes through a per-lane pixel transform on the way.
// Reads are issued only on one hcount phase, so the copy shares the source
// bank with the display path. The copy starts at the next frame origin.
//
// Ports:
//   clk, reset        sole clock; synchronous active-high reset
//   start             one-cycle request to copy one frame (only seen in IDLE)
//   mode, thresh      transform select (0 pass, 1 invert, 2 threshold, 3 fill)
//   hcount, vcount    display raster position
//   rd_addr, rd_data  source bank; data valid READ_LAT clocks after the address
//   wr_addr, wr_data  destination bank write port, qualified by wr_en
//   busy, done        busy is high while a copy is in progress; done pulses
//                     when the copy completes
module zbt_frame_copier #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned PIX_W       = 9,
  parameter int unsigned DATA_W      = 36,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned READ_LAT    = 2,
  parameter logic [1:0]  SLOT        = 2'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  thresh,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     LANES     = DATA_W / PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_COPY  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [ADDR_W-1:0]   ptr;
  logic [1:0]          mode_q;
  logic [PIX_W-1:0]    thresh_q;
  logic [READ_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0]   pipe_a [READ_LAT];
  logic                issue_c;
  logic                origin_c;
  logic                pipe_empty_c;

  assign issue_c      = (state == S_COPY) && (hcount[1:0] == SLOT);
  assign origin_c     = (hcount == 11'd0) && (vcount == 10'd0);
  assign pipe_empty_c = (pipe_v == '0);

  // Per-lane pixel transform applied to each word on its way to the destination.
  function automatic logic [DATA_W-1:0] xform(input logic [1:0]        m,
                                               input logic [PIX_W-1:0]  th,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (m)
        2'd0:    r[i*PIX_W +: PIX_W] = d[i*PIX_W +: PIX_W];
        2'd1:    r[i*PIX_W +: PIX_W] = ~d[i*PIX_W +: PIX_W];
        2'd2:    r[i*PIX_W +: PIX_W] = (d[i*PIX_W +: PIX_W] >= th) ? '1 : '0;
        default: r[i*PIX_W +: PIX_W] = '1;
      endcase
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_ALIGN;
      S_ALIGN: if (origin_c) next_state = S_COPY;
      S_COPY:  if (issue_c && (ptr == LAST_ADDR)) next_state = S_DRAIN;
      S_DRAIN: if (pipe_empty_c) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: read pointer, in-flight tag pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      pipe_v   <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) pipe_a[i] <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end

      // Pointer saturates at the last address; DRAIN stops further issues.
      if ((state == S_ALIGN) && origin_c) ptr <= '0;
      else if (issue_c && (ptr != LAST_ADDR)) ptr <= ptr + ADDR_W'(1);

      if (issue_c) rd_addr <= ptr;

      // Tag pipeline tracks which address the returning rd_data belongs to.
      pipe_v[0] <= issue_c;
      pipe_a[0] <= ptr;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end

      wr_en <= pipe_v[READ_LAT-1];
      if (pipe_v[READ_LAT-1]) begin
        wr_addr <= pipe_a[READ_LAT-1];
        wr_data <= xform(mode_q, thresh_q, rd_data);
      end

      busy <= (next_state == S_ALIGN) || (next_state == S_COPY) ||
              (next_state == S_DRAIN);
      done <= (next_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_zbt_frame_copier.sv
// Directed bench for zbt_frame_copier with an 8-word frame and a behavioural
// ZBT source bank that has 2-clock read latency.
module tb_zbt_frame_copier;

  localparam int unsigned NW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [8:0]  thresh = 9'd0;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic [18:0] rd_addr;
  logic [35:0] rd_data;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  logic [35:0] mem   [NW];
  logic [35:0] exp_d [NW];
  logic [18:0] addr_q = 19'd0;
  logic [18:0] prev_rd = 19'd0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_t = 0;
  int wr_t  [NW];
  int iss_t [NW];

  zbt_frame_copier #(
    .ADDR_W(19), .PIX_W(9), .DATA_W(36), .FRAME_WORDS(NW), .READ_LAT(2),
    .SLOT(2'd1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .thresh(thresh),
    .hcount(hcount), .vcount(vcount), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Small raster: 16 columns x 2 lines, so the frame origin recurs every 32 clocks.
  always @(posedge clk) begin
    hcount <= (hcount == 11'd15) ? 11'd0 : hcount + 11'd1;
    if (hcount == 11'd15) vcount <= (vcount == 10'd1) ? 10'd0 : vcount + 10'd1;
  end

  // Source bank: address registered once, data presented during the next clock.
  always @(posedge clk) addr_q <= rd_addr;
  assign rd_data = mem[addr_q[2:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Write monitor: ascending addresses, transformed data, timing capture.
  always @(negedge clk) begin
    cyc++;
    if (rd_addr != prev_rd) iss_t[rd_addr[2:0]] = cyc;
    prev_rd = rd_addr;
    if (wr_en) begin
      check("wr_addr", 64'(wr_addr), 64'(wr_cnt));
      check("wr_data", 64'(wr_data), 64'(exp_d[wr_addr[2:0]]));
      if (wr_cnt < NW) wr_t[wr_cnt] = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_t = cyc;
    end
  end

  task automatic run_frame(input logic [1:0] m, input logic [8:0] th,
                           input bit disturb, input string tag);
    bit seen;
    bit poked;
    seen = 1'b0;
    poked = 1'b0;
    wr_cnt = 0;
    done_cnt = 0;
    mode = m;
    thresh = th;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (disturb && !poked && wr_cnt >= 3) begin
        mode = ~m;
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check({tag, " write_count"}, 64'(wr_cnt), 64'(NW));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " wr_addr_hold"}, 64'(wr_addr), 64'(NW - 1));
    check({tag, " first_wr_lat"}, 64'(wr_t[0]), 64'(iss_t[1] - 4 + 2));
    for (int k = 1; k < NW; k++)
      check({tag, " wr_lat"}, 64'(wr_t[k]), 64'(iss_t[k] + 2));
    check({tag, " done_after_last"}, 64'(done_t), 64'(wr_t[NW-1] + 1));
    repeat (3) @(negedge clk);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit hit;
    for (int k = 0; k < NW; k++) begin
      mem[k] = 36'(k);
      exp_d[k] = 36'(k);
    end

    // Reset with start held high: reset must win.
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst rd_addr", 64'(rd_addr), 64'd0);
    check("rst wr_addr", 64'(wr_addr), 64'd0);
    check("rst wr_data", 64'(wr_data), 64'd0);
    check("rst wr_en", 64'(wr_en), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle busy", 64'(busy), 64'd0);

    // Mode 0: pass-through, data equals address.
    run_frame(2'd0, 9'd0, 1'b0, "pass");

    // Mode 1: invert.
    for (int k = 0; k < NW; k++) begin
      mem[k] = 36'h0_0000_01FF;
      exp_d[k] = 36'hF_FFFF_FE00;
    end
    run_frame(2'd1, 9'd0, 1'b0, "invert");

    // Mode 2: threshold at 100; lane 0 is the least significant.
    for (int k = 0; k < NW; k++) begin
      if (k % 2 == 0) begin
        mem[k] = {9'd511, 9'd101, 9'd100, 9'd99};
        exp_d[k] = 36'hF_FFFF_FE00;
      end else begin
        mem[k] = {9'd0, 9'd100, 9'd0, 9'd100};
        exp_d[k] = 36'h0_07FC_01FF;
      end
    end
    run_frame(2'd2, 9'd100, 1'b0, "thresh");

    // Mode 3: fill, source ignored.
    for (int k = 0; k < NW; k++) begin
      mem[k] = {4'($urandom), 32'($urandom)};
      exp_d[k] = 36'hF_FFFF_FFFF;
    end
    run_frame(2'd3, 9'd0, 1'b0, "fill");

    // Start re-pulsed and mode flipped mid-copy: latched invert must hold.
    for (int k = 0; k < NW; k++) begin
      mem[k] = 36'(k);
      exp_d[k] = ~36'(k);
    end
    run_frame(2'd1, 9'd0, 1'b1, "restart_ignored");

    // Reset one clock after the third read issue.
    for (int k = 0; k < NW; k++) begin
      mem[k] = 36'(k);
      exp_d[k] = 36'(k);
    end
    wr_cnt = 0;
    done_cnt = 0;
    mode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_addr == 19'd2) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort third_issue_seen", 64'(hit), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort wr_en", 64'(wr_en), 64'd0);
    repeat (80) @(negedge clk);
    check("abort write_count", 64'(wr_cnt), 64'd2);
    check("abort no_done", 64'(done_cnt), 64'd0);
    check("abort busy_later", 64'(busy), 64'd0);

    // Full copy after the abort.
    run_frame(2'd0, 9'd0, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
